// File: rtl/axon_spike_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : axon_spike_scheduler_if
// Brief    : Fire-event input stream and due-spike output stream of the
//            axon spike scheduler (valid/ready on both sides).
// Revision : 1.0  initial release
// ============================================================================
interface axon_spike_scheduler_if #(
    parameter int TW    = 16,
    parameter int NID_W = 8
);
    logic             in_valid;
    logic [NID_W-1:0] in_nid;
    logic [TW-1:0]    in_delay;
    logic             in_ready;
    logic             out_valid;
    logic [NID_W-1:0] out_nid;
    logic [TW-1:0]    out_time;
    logic             out_ready;

    // master: soma side producing events and consumer accepting spikes
    modport master (
        output in_valid, in_nid, in_delay, out_ready,
        input  in_ready, out_valid, out_nid, out_time
    );

    modport slave (
        input  in_valid, in_nid, in_delay, out_ready,
        output in_ready, out_valid, out_nid, out_time
    );
endinterface
`default_nettype wire

// File: rtl/axon_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axon_spike_scheduler
// Brief    : Holds fire events in a slot table until the global timestep
//            reaches their due time, then streams them out in slot order.
// Revision : 1.0  initial release
// ============================================================================
module axon_spike_scheduler #(
    parameter int DEPTH = 8,
    parameter int TW    = 16,
    parameter int NID_W = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       tick,
    input  wire logic                       flush,
    axon_spike_scheduler_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic [TW-1:0]                   now,
    output logic                            sat_err
);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0]   c_DMAX    = {1'b0, {(TW-1){1'b1}}};
    localparam logic [TW-1:0]   c_T_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_C_ONE   = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);

    logic [DEPTH-1:0] r_vld;
    logic [NID_W-1:0] r_nid [DEPTH];
    logic [TW-1:0]    r_due [DEPTH];
    logic             r_out_valid;
    logic [NID_W-1:0] r_out_nid;
    logic [TW-1:0]    r_out_time;
    logic [c_CW-1:0]  r_count;
    logic [TW-1:0]    r_now;
    logic             r_sat;

    logic [TW-1:0]    w_diff [DEPTH];
    logic [DEPTH-1:0] w_due;
    logic [c_IW-1:0]  w_free_idx;
    logic [c_IW-1:0]  w_rel_idx;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_release;
    logic             w_sat;
    logic [TW-1:0]    w_delay;
    logic [TW-1:0]    w_due_new;
    logic [c_CW-1:0]  w_count_nxt;

    // A slot is due once now has reached its due time; the sign bit of the
    // modular difference stays correct across the counter wrap.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_diff[gi] = r_now - r_due[gi];
            assign w_due[gi]  = r_vld[gi] & ~w_diff[gi][TW-1];
        end
    endgenerate

    always_comb begin
        w_free_idx = '0;
        w_rel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_vld[i]) w_free_idx = c_IW'(i);
            if (w_due[i])  w_rel_idx  = c_IW'(i);
        end
    end

    assign w_in_ready = (r_count < c_FULL);
    assign w_accept   = bus.in_valid && w_in_ready && !flush;
    assign w_release  = (!r_out_valid || bus.out_ready) && (|w_due) && !flush;
    assign w_sat      = bus.in_delay[TW-1];
    assign w_delay    = w_sat ? c_DMAX : bus.in_delay;
    assign w_due_new  = r_now + w_delay;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_release})
            2'b10:   w_count_nxt = r_count + c_C_ONE;
            2'b01:   w_count_nxt = r_count - c_C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_out_nid   <= '0;
            r_out_time  <= '0;
            r_count     <= '0;
            r_now       <= '0;
            r_sat       <= 1'b0;
        end else begin
            if (tick) r_now <= r_now + c_T_ONE;
            if (flush) begin
                r_vld       <= '0;
                r_out_valid <= 1'b0;
                r_out_nid   <= '0;
                r_out_time  <= '0;
                r_count     <= '0;
                r_sat       <= 1'b0;
            end else begin
                if (w_release) begin
                    r_out_valid      <= 1'b1;
                    r_out_nid        <= r_nid[w_rel_idx];
                    r_out_time       <= r_due[w_rel_idx];
                    r_vld[w_rel_idx] <= 1'b0;
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
                // The write target is a currently free slot, so it can never
                // collide with the slot released at this edge.
                if (w_accept) begin
                    r_vld[w_free_idx] <= 1'b1;
                    if (w_sat) r_sat <= 1'b1;
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Slot payload needs no reset: it is only observed behind r_vld.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_nid[w_free_idx] <= bus.in_nid;
            r_due[w_free_idx] <= w_due_new;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_nid   = r_out_nid;
    assign bus.out_time  = r_out_time;
    assign count         = r_count;
    assign now           = r_now;
    assign sat_err       = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_axon_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_axon_spike_scheduler
// Brief    : Directed scenarios plus randomized traffic against a slot-table
//            reference model for axon_spike_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_axon_spike_scheduler;
    localparam int DEPTH = 8;
    localparam int TW    = 16;
    localparam int NID_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  count;
    logic [15:0] now;
    logic        sat_err;
    int          checks = 0;
    int          errors = 0;

    axon_spike_scheduler_if #(.TW(TW), .NID_W(NID_W)) bus ();

    axon_spike_scheduler #(.DEPTH(DEPTH), .TW(TW), .NID_W(NID_W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .flush(flush), .bus(bus),
        .count(count), .now(now), .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        tick = 0; flush = 0;
        bus.in_valid = 0; bus.in_nid = '0; bus.in_delay = '0; bus.out_ready = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); step(); rst = 0;
    endtask

    task automatic push(input logic [7:0] nid, input logic [15:0] d);
        bus.in_valid = 1; bus.in_nid = nid; bus.in_delay = d;
        step();
        bus.in_valid = 0;
    endtask

    task automatic ticks(input int n);
        tick = 1; repeat (n) step(); tick = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", bus.out_valid); end
        checks++; if (bus.out_nid !== 8'h00) begin errors++; $display("FAIL reset_out_nid got %h exp 00", bus.out_nid); end
        checks++; if (bus.out_time !== 16'h0000) begin errors++; $display("FAIL reset_out_time got %h exp 0000", bus.out_time); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (now !== 16'h0000) begin errors++; $display("FAIL reset_now got %h exp 0000", now); end
        checks++; if (sat_err !== 1'b0) begin errors++; $display("FAIL reset_sat_err got %0d exp 0", sat_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", bus.in_ready); end
        rst = 0;
    endtask

    task automatic test_basic();
        do_reset(); bus.out_ready = 1;
        push(8'h12, 16'd3);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", count); end
        ticks(3);
        checks++; if (now !== 16'd3) begin errors++; $display("FAIL basic_now got %0d exp 3", now); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0d exp 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", bus.out_valid); end
        checks++; if (bus.out_nid !== 8'h12) begin errors++; $display("FAIL basic_nid got %h exp 12", bus.out_nid); end
        checks++; if (bus.out_time !== 16'd3) begin errors++; $display("FAIL basic_time got %0d exp 3", bus.out_time); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0 got %0d exp 0", count); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %0d exp 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'(i), 16'd100);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0d exp 0", bus.in_ready); end
        bus.in_valid = 1; bus.in_nid = 8'hAA; bus.in_delay = 16'd1;
        step(); step();
        bus.in_valid = 0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_held got %0d exp 8", count); end
        ticks(100);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_early got %0d exp 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'h00) begin errors++; $display("FAIL full_first got v=%0d nid=%h exp v=1 nid=00", bus.out_valid, bus.out_nid); end
        checks++; if (bus.in_ready !== 1'b1 || count !== 4'd7) begin errors++; $display("FAIL full_free got rdy=%0d cnt=%0d exp rdy=1 cnt=7", bus.in_ready, count); end
        bus.out_ready = 1;
        for (int k = 1; k < DEPTH; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'(k) || count !== 4'(7 - k)) begin
                errors++; $display("FAIL full_drain%0d got v=%0d nid=%h cnt=%0d exp v=1 nid=%h cnt=%0d", k, bus.out_valid, bus.out_nid, count, k, 7 - k);
            end
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0d exp 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        push(8'd5, 16'd10); push(8'd9, 16'd10);
        ticks(10); step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'd5 || bus.out_time !== 16'd10) begin
            errors++; $display("FAIL stall_first got v=%0d nid=%0d t=%0d exp v=1 nid=5 t=10", bus.out_valid, bus.out_nid, bus.out_time);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'd5 || bus.out_time !== 16'd10 || count !== 4'd1) begin
                errors++; $display("FAIL stall_hold%0d got v=%0d nid=%0d t=%0d cnt=%0d exp v=1 nid=5 t=10 cnt=1", k, bus.out_valid, bus.out_nid, bus.out_time, count);
            end
        end
        bus.out_ready = 1; step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'd9) begin errors++; $display("FAIL stall_second got v=%0d nid=%0d exp v=1 nid=9", bus.out_valid, bus.out_nid); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %0d exp 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_sat_wrap();
        do_reset();
        push(8'h33, 16'h9000);
        checks++; if (sat_err !== 1'b1) begin errors++; $display("FAIL sat_flag got %0d exp 1", sat_err); end
        ticks(32767);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sat_early got %0d exp 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'h33 || bus.out_time !== 16'h7FFF) begin
            errors++; $display("FAIL sat_time got v=%0d nid=%h t=%h exp v=1 nid=33 t=7fff", bus.out_valid, bus.out_nid, bus.out_time);
        end
        bus.out_ready = 1; step(); bus.out_ready = 0;
        ticks(32767);
        checks++; if (now !== 16'hFFFE) begin errors++; $display("FAIL wrap_now got %h exp fffe", now); end
        push(8'h44, 16'd4);
        tick = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_early%0d got %0d exp 0 now=%h", k, bus.out_valid, now); end
        end
        tick = 0;
        checks++; if (now !== 16'd2) begin errors++; $display("FAIL wrap_now2 got %h exp 0002", now); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_nid !== 8'h44 || bus.out_time !== 16'd2) begin
            errors++; $display("FAIL wrap_due got v=%0d nid=%h t=%h exp v=1 nid=44 t=0002", bus.out_valid, bus.out_nid, bus.out_time);
        end
        idle();
    endtask

    task automatic test_flush_reset();
        do_reset();
        ticks(5);
        push(8'd1, 16'd0); push(8'd2, 16'd50); push(8'd3, 16'h8000); push(8'd4, 16'd60);
        checks++; if (count !== 4'd3 || bus.out_valid !== 1'b1 || bus.out_nid !== 8'd1 || bus.out_time !== 16'd5 || sat_err !== 1'b1) begin
            errors++; $display("FAIL flush_setup got cnt=%0d v=%0d nid=%0d t=%0d sat=%0d exp 3 1 1 5 1", count, bus.out_valid, bus.out_nid, bus.out_time, sat_err);
        end
        flush = 1; tick = 1; bus.in_valid = 1; bus.in_nid = 8'h77; bus.in_delay = 16'd0;
        step();
        flush = 0; tick = 0; bus.in_valid = 0;
        checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_nid !== 8'd0 || bus.out_time !== 16'd0 || sat_err !== 1'b0) begin
            errors++; $display("FAIL flush_clear got cnt=%0d v=%0d nid=%0d t=%0d sat=%0d exp 0 0 0 0 0", count, bus.out_valid, bus.out_nid, bus.out_time, sat_err);
        end
        checks++; if (now !== 16'd6 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_now got now=%0d rdy=%0d exp now=6 rdy=1", now, bus.in_ready); end
        step(); step();
        checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got cnt=%0d v=%0d exp 0 0", count, bus.out_valid); end
        push(8'd1, 16'd0); push(8'd2, 16'd50); push(8'd3, 16'h8000); push(8'd4, 16'd60);
        #3; rst = 1; tick = 1; #1;
        checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_nid !== 8'd0 || bus.out_time !== 16'd0 || sat_err !== 1'b0 || now !== 16'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst got cnt=%0d v=%0d nid=%0d t=%0d sat=%0d now=%0d rdy=%0d exp 0 0 0 0 0 0 1", count, bus.out_valid, bus.out_nid, bus.out_time, sat_err, now, bus.in_ready);
        end
        step(); rst = 0; idle();
    endtask

    task automatic test_random();
        bit          m_vld [DEPTH];
        logic [7:0]  m_nid [DEPTH];
        int          m_due [DEPTH];
        int          m_now, m_otime, m_onid, cnt, free_s, rel_s, d, dd;
        bit          m_ov, m_sat, t, f, iv, ordy, acc;
        logic [7:0]  nid;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin m_vld[i] = 0; m_nid[i] = 0; m_due[i] = 0; end
        m_now = 0; m_otime = 0; m_onid = 0; m_ov = 0; m_sat = 0;
        for (int n = 0; n < 3000; n++) begin
            t = ($urandom_range(0, 1) == 0);
            f = ($urandom_range(0, 60) == 0);
            iv = $urandom_range(0, 1);
            ordy = ($urandom_range(0, 3) != 0);
            nid = 8'($urandom);
            d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12));
            tick = t; flush = f; bus.in_valid = iv; bus.in_nid = nid; bus.in_delay = 16'(d); bus.out_ready = ordy;
            cnt = 0;
            foreach (m_vld[i]) cnt += m_vld[i];
            acc = iv && (cnt < DEPTH) && !f;
            free_s = -1; rel_s = -1;
            for (int i = 0; i < DEPTH; i++) if (!m_vld[i] && free_s < 0) free_s = i;
            if (!m_ov || ordy)
                for (int i = 0; i < DEPTH; i++)
                    if (m_vld[i] && ((m_now - m_due[i] + 65536) % 65536) < 32768 && rel_s < 0) rel_s = i;
            if (f) begin
                foreach (m_vld[i]) m_vld[i] = 0;
                m_ov = 0; m_onid = 0; m_otime = 0; m_sat = 0;
            end else begin
                if (rel_s >= 0) begin
                    m_ov = 1; m_onid = m_nid[rel_s]; m_otime = m_due[rel_s]; m_vld[rel_s] = 0;
                end else if (ordy) m_ov = 0;
                if (acc) begin
                    dd = (d >= 32768) ? 32767 : d;
                    if (d >= 32768) m_sat = 1;
                    m_vld[free_s] = 1; m_nid[free_s] = nid; m_due[free_s] = (m_now + dd) % 65536;
                end
            end
            if (t) m_now = (m_now + 1) % 65536;
            step();
            cnt = 0;
            foreach (m_vld[i]) cnt += m_vld[i];
            checks++; if (bus.out_valid !== m_ov || bus.out_nid !== 8'(m_onid) || bus.out_time !== 16'(m_otime)) begin
                errors++; $display("FAIL rand_out@%0d got v=%0d nid=%h t=%h exp v=%0d nid=%h t=%h", n, bus.out_valid, bus.out_nid, bus.out_time, m_ov, 8'(m_onid), 16'(m_otime));
            end
            checks++; if (count !== 4'(cnt) || bus.in_ready !== (cnt < DEPTH) || now !== 16'(m_now) || sat_err !== m_sat) begin
                errors++; $display("FAIL rand_state@%0d got cnt=%0d rdy=%0d now=%h sat=%0d exp cnt=%0d rdy=%0d now=%h sat=%0d", n, count, bus.in_ready, now, sat_err, cnt, cnt < DEPTH, 16'(m_now), m_sat);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_sat_wrap();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
